// File: rtl/pkt_buf_reader_if.sv
// Interface bundling the descriptor input, RAM port-B and output stream
// signals of the packet buffer reader.
interface pkt_buf_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 12
);
    // descriptor channel
    logic                  desc_valid;
    logic                  desc_ready;
    logic [ADDR_WIDTH-1:0] desc_addr;
    logic [LEN_WIDTH-1:0]  desc_len;

    // RAM read port (port B)
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;

    // output stream
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // status
    logic                  busy;

    // reader side
    modport master (
        input  desc_valid, desc_addr, desc_len, ram_dout, out_ready,
        output desc_ready, ram_addr, ram_we, ram_din,
               out_valid, out_data, out_last, busy
    );

    // descriptor source / RAM / stream sink side
    modport slave (
        output desc_valid, desc_addr, desc_len, ram_dout, out_ready,
        input  desc_ready, ram_addr, ram_we, ram_din,
               out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/pkt_buf_reader.sv
// Packet buffer reader: takes one {addr, len} descriptor, streams len words
// out of the packet RAM read port with circular address wrap, and hides the
// RAM's 1-cycle read latency behind a 3-entry output FIFO.
module pkt_buf_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = 2048,
    parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
    parameter int LEN_WIDTH   = 12
) (
    input  logic               clock,
    input  logic               reset,
    pkt_buf_reader_if.master   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LP_ADDR_MAX = ADDR_WIDTH'(NUM_ENTRIES - 1);
    localparam logic [LEN_WIDTH-1:0]  LP_LEN_ONE  = LEN_WIDTH'(1);

    // control state
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_inflight;
    logic                  r_last_tag;

    // output FIFO: entry = {last, data}
    logic [DATA_WIDTH:0]   r_mem [3];
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic [1:0]            r_count;

    logic                  w_desc_hs;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drain_done;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [2:0]            w_occupancy;
    logic [DATA_WIDTH:0]   w_head;

    // 3-entry ring pointer advance
    function automatic logic [1:0] f_ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue throttle only looks at registered state, so out_ready never
    // reaches ram_addr or desc_ready combinationally.
    always_comb begin
        w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight};
        w_desc_hs    = (r_state == ST_IDLE) && bus.desc_valid;
        w_issue      = (r_state == ST_READ) && (r_rem != '0) && (w_occupancy < 3'd3);
        w_addr_nxt   = (r_addr == LP_ADDR_MAX) ? '0 : r_addr + 1'b1;
        w_push       = r_inflight;
        w_pop        = (r_count != 2'd0) && bus.out_ready;
        // Leave DRAIN at the edge where the final word pops, so desc_ready
        // rises in the very next cycle.
        w_drain_done = (r_state == ST_DRAIN) && !r_inflight &&
                       ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));
        w_head       = r_mem[r_rptr];
    end

    // descriptor latch, address/remaining bookkeeping and state transitions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_desc_hs) begin
                        r_addr <= bus.desc_addr;
                        r_rem  <= bus.desc_len;
                        // a zero-length packet is consumed without leaving IDLE
                        if (bus.desc_len != '0)
                            r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_addr <= w_addr_nxt;
                        r_rem  <= r_rem - LP_LEN_ONE;
                        if (r_rem == LP_LEN_ONE)
                            r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_done)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // in-flight marker for the word the RAM returns next cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inflight <= 1'b0;
            r_last_tag <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_last_tag <= w_issue && (r_rem == LP_LEN_ONE);
        end
    end

    // FIFO storage; contents are don't-care until count says otherwise
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= {r_last_tag, bus.ram_dout};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 2'd0;
        end else begin
            if (w_push)
                r_wptr <= f_ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= f_ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The issue throttle guarantees room for every in-flight word.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(w_push && (r_count == 2'd3) && !w_pop));

    assign bus.desc_ready = (r_state == ST_IDLE);
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ram_addr   = r_addr;
    assign bus.ram_we     = 1'b0;
    assign bus.ram_din    = '0;
    assign bus.out_valid  = (r_count != 2'd0);
    // head is masked so stale FIFO contents never show on an idle stream
    assign bus.out_data   = bus.out_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign bus.out_last   = bus.out_valid && w_head[DATA_WIDTH];

endmodule

// File: tb/tb_pkt_buf_reader.sv
// Directed bench for pkt_buf_reader with a behavioural 1-cycle-latency RAM.
module tb_pkt_buf_reader;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;

    pkt_buf_reader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .LEN_WIDTH(12)) bus();

    pkt_buf_reader #(
        .DATA_WIDTH(32), .NUM_ENTRIES(2048), .ADDR_WIDTH(11), .LEN_WIDTH(12)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered read, data valid the cycle after the address
    logic [31:0] mem [2048];
    always @(posedge clock) bus.ram_dout <= mem[bus.ram_addr];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] got_d [32];
    logic        got_l [32];
    int          got_c [32];
    int          got_n;
    int          max_out;
    logic [10:0] start_addr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // hs = index of the edge at which the descriptor was accepted
    task automatic send_desc(input logic [10:0] a, input logic [11:0] l, output int hs);
        bus.desc_valid = 1'b1;
        bus.desc_addr  = a;
        bus.desc_len   = l;
        hs = -1;
        for (int k = 0; k < 200 && hs < 0; k++) begin
            if (bus.desc_ready) hs = cyc + 1;
            step();
        end
        bus.desc_valid = 1'b0;
        if (hs < 0) chk("desc_timeout", 64'd0, 64'd1);
        start_addr = a;
    endtask

    // pops n words; out_ready follows pat; tracks count+inflight via ram_addr
    task automatic collect(input int n, input logic [15:0] pat, input int budget);
        int          c;
        int          out_now;
        logic [10:0] diff;
        got_n   = 0;
        max_out = 0;
        c       = 0;
        while (got_n < n && c < budget) begin
            bus.out_ready = pat[c % 16];
            diff    = bus.ram_addr - start_addr;
            out_now = int'(diff) - got_n;
            if (out_now > max_out) max_out = out_now;
            if (bus.out_valid && bus.out_ready) begin
                got_d[got_n] = bus.out_data;
                got_l[got_n] = bus.out_last;
                got_c[got_n] = cyc;
                got_n++;
            end
            if (got_n < n) step();
            c++;
        end
        if (got_n < n) chk("collect_timeout", 64'(got_n), 64'(n));
    endtask

    initial begin
        int          hs, hs2;
        logic [31:0] e8 [8];
        logic        seen;

        for (int i = 0; i < 2048; i++) mem[i] = {16'hCAFE, 16'(i)};
        mem[10] = 32'h0000_00A0;
        mem[11] = 32'h0000_00A1;
        mem[12] = 32'h0000_00A2;
        mem[13] = 32'h0000_00A3;

        reset          = 1'b1;
        bus.desc_valid = 1'b0;
        bus.desc_addr  = '0;
        bus.desc_len   = '0;
        bus.out_ready  = 1'b0;
        repeat (3) step();

        // reset state
        chk("rst_desc_ready", 64'(bus.desc_ready), 64'd1);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_out_last",   64'(bus.out_last),   64'd0);
        chk("rst_out_data",   64'(bus.out_data),   64'd0);
        chk("rst_ram_addr",   64'(bus.ram_addr),   64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("ram_we",         64'(bus.ram_we),     64'd0);
        chk("ram_din",        64'(bus.ram_din),    64'd0);
        reset = 1'b0;
        step();

        // basic: addr 10 len 4
        bus.out_ready = 1'b1;
        send_desc(11'd10, 12'd4, hs);
        chk("basic_busy", 64'(bus.busy), 64'd1);
        chk("basic_dready_lo", 64'(bus.desc_ready), 64'd0);
        collect(4, 16'hFFFF, 50);
        e8[0] = 32'hA0; e8[1] = 32'hA1; e8[2] = 32'hA2; e8[3] = 32'hA3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("basic_data%0d", i), 64'(got_d[i]), 64'(e8[i]));
            chk($sformatf("basic_last%0d", i), 64'(got_l[i]), (i == 3) ? 64'd1 : 64'd0);
            chk($sformatf("basic_cyc%0d", i),  64'(got_c[i] - hs), 64'(2 + i));
        end
        chk("basic_dready_at_pop", 64'(bus.desc_ready), 64'd0);
        step();
        chk("basic_dready_after", 64'(bus.desc_ready), 64'd1);
        chk("basic_busy_after",   64'(bus.busy),       64'd0);
        step();

        // wrap: 2046,2047,0,1
        send_desc(11'd2046, 12'd4, hs);
        collect(4, 16'hFFFF, 50);
        e8[0] = 32'hCAFE07FE; e8[1] = 32'hCAFE07FF; e8[2] = 32'hCAFE0000; e8[3] = 32'hCAFE0001;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_data%0d", i), 64'(got_d[i]), 64'(e8[i]));
            chk($sformatf("wrap_last%0d", i), 64'(got_l[i]), (i == 3) ? 64'd1 : 64'd0);
        end
        step();
        step();

        // backpressure: ready pattern 1,0,0,0,1,1,0,1 repeating
        send_desc(11'd20, 12'd8, hs);
        collect(8, 16'hB1B1, 200);
        e8[0] = 32'hCAFE0014; e8[1] = 32'hCAFE0015; e8[2] = 32'hCAFE0016; e8[3] = 32'hCAFE0017;
        e8[4] = 32'hCAFE0018; e8[5] = 32'hCAFE0019; e8[6] = 32'hCAFE001A; e8[7] = 32'hCAFE001B;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("bp_data%0d", i), 64'(got_d[i]), 64'(e8[i]));
            chk($sformatf("bp_last%0d", i), 64'(got_l[i]), (i == 7) ? 64'd1 : 64'd0);
        end
        chk("bp_max_outstanding", 64'(max_out), 64'd3);
        step();
        bus.out_ready = 1'b1;
        step();

        // zero length then single word
        send_desc(11'd7, 12'd0, hs);
        chk("zero_busy",   64'(bus.busy),       64'd0);
        chk("zero_dready", 64'(bus.desc_ready), 64'd1);
        chk("zero_valid",  64'(bus.out_valid),  64'd0);
        send_desc(11'd5, 12'd1, hs2);
        chk("zero_next_accept", 64'(hs2 - hs), 64'd1);
        collect(1, 16'hFFFF, 50);
        chk("single_data", 64'(got_d[0]), 64'h0000_0000_CAFE_0005);
        chk("single_last", 64'(got_l[0]), 64'd1);
        chk("single_cyc",  64'(got_c[0] - hs2), 64'd2);
        step();
        step();

        // back-to-back descriptors, desc_valid held high throughout
        fork
            begin
                send_desc(11'd300, 12'd3, hs);
                send_desc(11'd400, 12'd5, hs2);
            end
            collect(8, 16'hFFFF, 200);
        join
        e8[0] = 32'hCAFE012C; e8[1] = 32'hCAFE012D; e8[2] = 32'hCAFE012E; e8[3] = 32'hCAFE0190;
        e8[4] = 32'hCAFE0191; e8[5] = 32'hCAFE0192; e8[6] = 32'hCAFE0193; e8[7] = 32'hCAFE0194;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b2b_data%0d", i), 64'(got_d[i]), 64'(e8[i]));
            chk($sformatf("b2b_last%0d", i), 64'(got_l[i]), (i == 2 || i == 7) ? 64'd1 : 64'd0);
        end
        chk("b2b_second_accept", 64'(hs2 - got_c[2]), 64'd2);
        step();
        step();

        // reset mid-packet
        send_desc(11'd200, 12'd16, hs);
        collect(5, 16'hFFFF, 50);
        step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        chk("mid_pre_valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid",  64'(bus.out_valid),  64'd0);
        chk("mid_rst_busy",   64'(bus.busy),       64'd0);
        chk("mid_rst_dready", 64'(bus.desc_ready), 64'd1);
        chk("mid_rst_addr",   64'(bus.ram_addr),   64'd0);
        step();
        step();
        reset = 1'b0;
        step();
        bus.out_ready = 1'b1;
        send_desc(11'd100, 12'd2, hs);
        collect(2, 16'hFFFF, 50);
        chk("mid_data0", 64'(got_d[0]), 64'h0000_0000_CAFE_0064);
        chk("mid_data1", 64'(got_d[1]), 64'h0000_0000_CAFE_0065);
        chk("mid_last0", 64'(got_l[0]), 64'd0);
        chk("mid_last1", 64'(got_l[1]), 64'd1);
        chk("mid_cyc0",  64'(got_c[0] - hs), 64'd2);
        step();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("mid_no_stale", 64'(seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
